// File: rtl/wb_pkg.sv
// Shared writeback-stage types: the entry payload layout and the skid occupancy encoding.
package wb_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_RADDR_W = 5;

    typedef struct packed {
        logic                  regwrite;
        logic                  mem_to_reg;
        logic [WB_DATA_W-1:0]  c;
        logic [WB_DATA_W-1:0]  read;
        logic [WB_RADDR_W-1:0] wnum;
    } wb_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_t;

    function automatic int payload_width(input int data_w, input int raddr_w);
        return 2 + 2 * data_w + raddr_w;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer; head visible one cycle after acceptance.
// in_ready comes straight from a register, so a stall never forms a combinational ready path.
module skid_buf
    import wb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    wb_state_t    state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         acc;
    logic         drn;

    assign acc      = in_valid & in_ready;
    assign drn      = out_valid & out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Flush wins over any accept or drain in the same cycle; payload is left stale.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_q    <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (drn && acc) begin
                        main_q <= in_data;
                    end else if (drn) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (acc) begin
                        skid_q   <= in_data;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end
                end
                TWO: begin
                    if (drn) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM->WB pipeline register over a 2-entry skid, producing the register-file write port.
// Optional build macro WB_RETIRE_CNT_EN adds a 32-bit retired-entry counter output.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_regwrite,
    input  logic               in_mem_to_reg,
    input  logic [DATA_W-1:0]  in_c,
    input  logic [DATA_W-1:0]  in_read,
    input  logic [RADDR_W-1:0] in_wnum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]        retire_cnt
`endif
);

    typedef struct packed {
        logic               regwrite;
        logic               mem_to_reg;
        logic [DATA_W-1:0]  c;
        logic [DATA_W-1:0]  read;
        logic [RADDR_W-1:0] wnum;
    } payload_t;

    localparam int PW = payload_width(DATA_W, RADDR_W);

    payload_t in_pl;
    payload_t head;
    logic     wnum_is_zero;

    assign in_pl = '{regwrite:   in_regwrite,
                     mem_to_reg: in_mem_to_reg,
                     c:          in_c,
                     read:       in_read,
                     wnum:       in_wnum};

    skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign wnum_is_zero = (head.wnum == '0);
    assign rf_waddr     = head.wnum;
    assign rf_wdata     = head.mem_to_reg ? head.read : head.c;
    // Qualifying with out_ready makes the write land exactly once, on the drain cycle.
    assign rf_we        = out_valid & head.regwrite & out_ready & ~(ZERO_REG & wnum_is_zero);

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (!flush && out_valid && out_ready) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomized and directed checks of wb_stage_pipe against a queue-based reference model.
module tb_wb_stage_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          regwrite;
        logic          mem_to_reg;
        logic [DW-1:0] c;
        logic [DW-1:0] read;
        logic [AW-1:0] wnum;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_regwrite = 1'b0;
    logic          in_mem_to_reg = 1'b0;
    logic [DW-1:0] in_c = '0;
    logic [DW-1:0] in_read = '0;
    logic [AW-1:0] in_wnum = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          in_ready_b, out_valid_b, rf_we_b;
    logic [AW-1:0] rf_waddr_b;
    logic [DW-1:0] rf_wdata_b;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]   retire_cnt, retire_cnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ent_t        q[$];
    logic [31:0] m_cnt = '0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DATA_W(DW), .RADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_mem_to_reg(in_mem_to_reg), .in_c(in_c),
        .in_read(in_read), .in_wnum(in_wnum), .out_valid(out_valid), .out_ready(out_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    wb_stage_pipe #(.DATA_W(DW), .RADDR_W(AW), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_regwrite(in_regwrite), .in_mem_to_reg(in_mem_to_reg), .in_c(in_c),
        .in_read(in_read), .in_wnum(in_wnum), .out_valid(out_valid_b), .out_ready(out_ready),
        .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then compare against the model.
    task automatic apply(input logic v, input logic rw, input logic m2r, input logic [DW-1:0] c,
                         input logic [DW-1:0] rd, input logic [AW-1:0] wn,
                         input logic ordy, input logic fl);
        logic exp_ov;
        @(negedge clk);
        in_valid = v; in_regwrite = rw; in_mem_to_reg = m2r;
        in_c = c; in_read = rd; in_wnum = wn; out_ready = ordy; flush = fl;
        #1;
        exp_ov = (q.size() > 0);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, q.size() < 2);
        chk("in_ready_nz", in_ready_b, q.size() < 2);
        if (exp_ov) begin
            chk("rf_waddr", rf_waddr, q[0].wnum);
            chk("rf_wdata", rf_wdata, q[0].mem_to_reg ? q[0].read : q[0].c);
            chk("rf_we", rf_we, q[0].regwrite && ordy && (q[0].wnum != 0));
            chk("rf_we_nz", rf_we_b, q[0].regwrite && ordy);
        end else begin
            chk("rf_we_idle", rf_we, 1'b0);
            chk("rf_we_nz_idle", rf_we_b, 1'b0);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
    endtask

    // Commit the cycle in the model, then let the clock edge happen.
    task automatic advance();
        logic a, d;
        ent_t e;
        a = in_valid && (q.size() < 2);
        d = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (d) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (a) begin
                e.regwrite = in_regwrite; e.mem_to_reg = in_mem_to_reg;
                e.c = in_c; e.read = in_read; e.wnum = in_wnum;
                q.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy);
        apply(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, '0);
        chk("rst_rf_wdata", rf_wdata, '0);
        rst = 1'b0;

        // Single ALU-result entry
        apply(1, 1, 0, 32'h1234, 32'hDEAD, 5'd5, 1, 0); advance();
        idle(1);
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_rf_we", rf_we, 1'b1);
        chk("t1_rf_waddr", rf_waddr, 5'd5);
        chk("t1_rf_wdata", rf_wdata, 32'h1234);
        advance();

        // Memory-data writeback
        apply(1, 1, 1, 32'h1, 32'hCAFEBABE, 5'd7, 1, 0); advance();
        idle(1);
        chk("t2_rf_wdata", rf_wdata, 32'hCAFEBABE);
        advance();

        // Register 0 destination
        apply(1, 1, 1, 32'h1, 32'hCAFEBABE, 5'd0, 1, 0); advance();
        idle(1);
        chk("t3_out_valid", out_valid, 1'b1);
        chk("t3_rf_we_zero", rf_we, 1'b0);
        chk("t3_rf_we_nz", rf_we_b, 1'b1);
        advance();

        // Backpressure: A, B fill the stage, C is held by the source
        apply(1, 1, 0, 32'hA, 0, 5'd1, 0, 0); advance();
        apply(1, 1, 0, 32'hB, 0, 5'd2, 0, 0); advance();
        apply(1, 1, 0, 32'hC, 0, 5'd3, 0, 0);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head", rf_waddr, 5'd1);
        advance();
        apply(1, 1, 0, 32'hC, 0, 5'd3, 1, 0);
        chk("bp_drain_a", rf_wdata, 32'hA);
        advance();
        apply(1, 1, 0, 32'hC, 0, 5'd3, 1, 0);
        chk("bp_drain_b", rf_wdata, 32'hB);
        advance();
        idle(1);
        chk("bp_drain_c", rf_wdata, 32'hC);
        advance();

        // Flush while holding two entries, with a valid input in the same cycle
        apply(1, 1, 0, 32'h11, 0, 5'd4, 0, 0); advance();
        apply(1, 1, 0, 32'h22, 0, 5'd6, 0, 0); advance();
        apply(1, 1, 0, 32'h33, 0, 5'd8, 0, 1); advance();
        idle(1);
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_rf_we", rf_we, 1'b0);
        advance();
        idle(1); advance();

        // Asynchronous reset while holding two entries
        apply(1, 1, 1, 32'h44, 32'h55, 5'd9, 0, 0); advance();
        apply(1, 1, 1, 32'h66, 32'h77, 5'd10, 0, 0); advance();
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_rf_we", rf_we, 1'b0);
        chk("ar_rf_waddr", rf_waddr, '0);
        chk("ar_rf_wdata", rf_wdata, '0);
        q.delete();
        m_cnt = '0;
        #1 rst = 1'b0;

        // Ten retired entries followed by three flushed ones
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 0, 32'($urandom), 32'($urandom), 5'(i + 1), 1, 0); advance();
        end
        idle(1); advance();
        apply(1, 1, 0, 32'h1, 0, 5'd1, 0, 0); advance();
        apply(1, 1, 0, 32'h2, 0, 5'd2, 0, 0); advance();
        apply(1, 1, 0, 32'h3, 0, 5'd3, 0, 1); advance();
        idle(1);
`ifdef WB_RETIRE_CNT_EN
        chk("rc_ten", retire_cnt, 32'd10);
`endif
        chk("rc_empty", out_valid, 1'b0);
        advance();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            apply($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 32'($urandom),
                  32'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised MEM->WB pipeline register, successor to the fixed-width WB latch. Carries the writeback control and data bundle over a valid/ready handshake and holds it through a 2-entry skid buffer, so stalls do not create a combinational ready path. Supports synchronous flush and produces the final register-file write port (data select, write enable, address).

Parameters:
DATA_W, 32, width of ALU result and memory read data
RADDR_W, 5, register-number width
ZERO_REG, 1, 1 = register 0 is hardwired, so writes to it are suppressed

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept an entry this cycle
in_regwrite  in  1  entry writes the register file
in_mem_to_reg  in  1  1 = writeback memory data, 0 = ALU result
in_c  in  DATA_W  ALU result
in_read  in  DATA_W  memory read data
in_wnum  in  RADDR_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts the head entry
rf_we  out  1  register-file write enable
rf_waddr  out  RADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data

Behaviour:
- Reset (async, active-high): all valid bits 0 and all payload registers 0. Resulting outputs: in_ready=1, out_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- Storage: a main entry (the head, which drives the outputs) and a skid entry. Each has its own valid bit and payload {regwrite, mem_to_reg, c, read, wnum}.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- in_ready = ~skid_valid. It is driven from a register only, with no combinational dependence on out_ready.
- Handshake events:
  - acc = in_valid & in_ready
  - drn = out_valid & out_ready
- Transitions when flush=0:
  - EMPTY: acc loads main -> ONE.
  - ONE:
    - drn & acc: main <= input, stay ONE.
    - drn only: -> EMPTY.
    - acc only: skid <= input -> TWO.
  - TWO: acc is impossible. drn: main <= skid, skid invalid -> ONE.
- Ordering: strictly FIFO, no reordering, no duplication.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 when the stage was EMPTY, or ONE with a drain in cycle N.
- Flush: has priority over every other event.
  - Next state is EMPTY and the cycle's input is dropped, even though in_ready may show 1.
  - Payload registers need not be cleared.
  - Flush during reset has no effect.
- out_valid = main_valid.
- rf_waddr = main.wnum.
- rf_wdata = main.mem_to_reg ? main.read : main.c (combinational from registers).
- rf_we = main_valid & main.regwrite & out_ready & ~(ZERO_REG & (main.wnum==0)). The write fires exactly once per entry, on its drain cycle.
- Back-to-back streaming with out_ready held at 1 sustains one entry per cycle.
- Reset asserted mid-stream discards all entries immediately (async).

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt (32 bit), reset 0. It increments by 1 on every drn cycle and wraps 0xFFFFFFFF->0.
  - Flushed entries are not counted.
- Not defined: the port and counter are absent and the rest of the behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - typedef wb_payload_t {regwrite, mem_to_reg, c[DATA_W], read[DATA_W], wnum[RADDR_W]}
  - state encoding constants EMPTY=2'd0, ONE=2'd1, TWO=2'd2
- Natural sub-module: skid_buf, a generic 2-entry valid/ready skid on a packed payload vector. wb_stage_pipe wraps it and adds the writeback mux and write-enable logic.

Test Plan:
- Reset, then one entry {regwrite=1, mem_to_reg=0, c=0x1234, read=0xDEAD, wnum=5} with out_ready=1 -> next cycle out_valid=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234.
- mem_to_reg=1, read=0xCAFEBABE, wnum=7 -> rf_wdata=0xCAFEBABE.
- Same entry with wnum=0 and ZERO_REG=1 -> rf_we=0 while out_valid=1. Repeat with ZERO_REG=0 -> rf_we=1.
- Backpressure:
  - out_ready=0, stream entries A, B, C -> A in main, B in skid, in_ready=0 and C held by the source.
  - Then out_ready=1 -> drain order A, B, C with no loss.
- Flush while in TWO with in_valid=1 -> next cycle out_valid=0 and in_ready=1. The dropped input never appears and rf_we is never asserted.
- Assert rst asynchronously (not on an edge) while holding 2 entries -> outputs zero immediately. With WB_RETIRE_CNT_EN defined: 10 drains then 3 flushed entries -> retire_cnt=10.
